// File: rtl/bram_tx_pkg.sv
// Shared definitions for the BRAM/response transmit scheduler: state encoding
// and default geometry constants.
package bram_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_CAPTURE = 2'd2
  } tx_state_e;

  localparam int DEF_ADDR_W    = 10;
  localparam int DEF_LAST_ADDR = 1023;

endpackage

// File: rtl/tx_holdoff_timer.sv
// Down-counter that masks uart_idle for IDLE_HOLDOFF cycles after each transmit
// strobe, giving the UART core time to drop its idle flag.
module tx_holdoff_timer #(
  parameter int IDLE_HOLDOFF = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  output logic zero_o
);

  localparam int CW = $clog2(IDLE_HOLDOFF + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(IDLE_HOLDOFF);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bram_tx_scheduler.sv
// Arbitrates the single UART transmitter between one-byte command responses and
// a sequential BRAM byte stream. Define BRAM_TX_LOOP_EN to wrap the stream at LAST_ADDR.
module bram_tx_scheduler
  import bram_tx_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int LAST_ADDR    = DEF_LAST_ADDR,
  parameter int IDLE_HOLDOFF = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rom_en,
  input  logic              resp_sig,
  input  logic [7:0]        resp_data,
  output logic              resp_drop,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [7:0]        bram_dout,
  input  logic              uart_idle,
  output logic              uart_tx_sig,
  output logic [7:0]        uart_tx_data,
  output logic              stream_active,
  output logic              stream_done
);

  tx_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic [7:0]        resp_q, resp_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              pend_q, pend_d;
  logic              rom_en_q;
  logic              active_q, active_d;
  logic              bram_en_q, bram_en_d;
  logic              tx_sig_q, tx_sig_d;
  logic              done_q, done_d;
  logic              drop_q, drop_d;
  logic              hold_load;
  logic              hold_zero;
  logic              slot_free;
  logic              grant_resp;

  tx_holdoff_timer #(
    .IDLE_HOLDOFF(IDLE_HOLDOFF)
  ) u_holdoff (
    .clk_i (clock),
    .rst_ni(reset),
    .load_i(hold_load),
    .zero_o(hold_zero)
  );

  assign slot_free  = hold_zero && uart_idle;
  assign grant_resp = (state_q == ST_IDLE) && slot_free && pend_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    bram_addr_d = bram_addr_q;
    resp_d      = resp_q;
    tx_data_d   = tx_data_q;
    pend_d      = pend_q;
    active_d    = active_q;
    bram_en_d   = 1'b0;
    tx_sig_d    = 1'b0;
    done_d      = 1'b0;
    drop_d      = 1'b0;
    hold_load   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (slot_free) begin
          if (pend_q) begin
            tx_data_d = resp_q;
            tx_sig_d  = 1'b1;
            pend_d    = 1'b0;
            hold_load = 1'b1;
          end else if (active_q) begin
            bram_en_d   = 1'b1;
            bram_addr_d = addr_q;
            state_d     = ST_READ;
          end
        end
      end
      ST_READ: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        tx_data_d = bram_dout;
        tx_sig_d  = 1'b1;
        hold_load = 1'b1;
        state_d   = ST_IDLE;
        if (addr_q == ADDR_W'(LAST_ADDR)) begin
          done_d = 1'b1;
`ifdef BRAM_TX_LOOP_EN
          addr_d = '0;
`else
          active_d = 1'b0;
`endif
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new response arriving on the same edge the old one is granted is not a drop.
    if (resp_sig) begin
      resp_d = resp_data;
      pend_d = 1'b1;
      if (pend_q && !grant_resp) begin
        drop_d = 1'b1;
      end
    end

    if (rom_en && !rom_en_q) begin
      active_d = 1'b1;
      addr_d   = '0;
    end else if (!rom_en) begin
      active_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      bram_addr_q <= '0;
      resp_q      <= '0;
      tx_data_q   <= '0;
      pend_q      <= 1'b0;
      rom_en_q    <= 1'b0;
      active_q    <= 1'b0;
      bram_en_q   <= 1'b0;
      tx_sig_q    <= 1'b0;
      done_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      bram_addr_q <= bram_addr_d;
      resp_q      <= resp_d;
      tx_data_q   <= tx_data_d;
      pend_q      <= pend_d;
      rom_en_q    <= rom_en;
      active_q    <= active_d;
      bram_en_q   <= bram_en_d;
      tx_sig_q    <= tx_sig_d;
      done_q      <= done_d;
      drop_q      <= drop_d;
    end
  end

  assign resp_drop     = drop_q;
  assign bram_en       = bram_en_q;
  assign bram_addr     = bram_addr_q;
  assign uart_tx_sig   = tx_sig_q;
  assign uart_tx_data  = tx_data_q;
  assign stream_active = active_q;
  assign stream_done   = done_q;

endmodule

// File: tb/tb_bram_tx_scheduler.sv
// Directed-plus-random bench for bram_tx_scheduler: a registered BRAM model, a
// UART model with random busy time, and a byte scoreboard of expected strobes.
module tb_bram_tx_scheduler;

  localparam int ADDR_W    = 4;
  localparam int LAST_ADDR = 3;
  localparam int HOLDOFF   = 2;
  localparam int NBYTES    = LAST_ADDR + 1;

  logic              clock     = 1'b0;
  logic              reset     = 1'b0;
  logic              rom_en    = 1'b0;
  logic              resp_sig  = 1'b0;
  logic [7:0]        resp_data = 8'h00;
  logic              resp_drop;
  logic              bram_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [7:0]        bram_dout = 8'h00;
  logic              uart_idle;
  logic              uart_tx_sig;
  logic [7:0]        uart_tx_data;
  logic              stream_active;
  logic              stream_done;

  bram_tx_scheduler #(
    .ADDR_W      (ADDR_W),
    .LAST_ADDR   (LAST_ADDR),
    .IDLE_HOLDOFF(HOLDOFF)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rom_en       (rom_en),
    .resp_sig     (resp_sig),
    .resp_data    (resp_data),
    .resp_drop    (resp_drop),
    .bram_en      (bram_en),
    .bram_addr    (bram_addr),
    .bram_dout    (bram_dout),
    .uart_idle    (uart_idle),
    .uart_tx_sig  (uart_tx_sig),
    .uart_tx_data (uart_tx_data),
    .stream_active(stream_active),
    .stream_done  (stream_done)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  // Registered-output BRAM.
  logic [7:0] mem [1 << ADDR_W];
  always @(posedge clock) begin
    if (bram_en) bram_dout <= mem[bram_addr];
  end

  // UART model: busy for a random number of cycles after each strobe.
  int   busy_cnt  = 0;
  int   busy_max  = 4;
  logic hold_busy = 1'b0;
  assign uart_idle = !hold_busy && (busy_cnt == 0);

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [7:0] got_q[$];
  bit         done_q[$];
  int         scyc_q[$];
  int         last_strobe = -100;
  int         drop_cnt    = 0;
  int         bram_cnt    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (uart_tx_sig) begin
      got_q.push_back(uart_tx_data);
      done_q.push_back(stream_done);
      scyc_q.push_back(cyc);
      chk("strobe_spacing_ok", 32'(cyc - last_strobe >= HOLDOFF + 1), 32'd1);
      last_strobe <= cyc;
      busy_cnt    <= $urandom_range(0, busy_max);
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (stream_done) chk("done_with_strobe", 32'(uart_tx_sig), 32'd1);
    if (resp_drop)   drop_cnt <= drop_cnt + 1;
    if (bram_en)     bram_cnt <= bram_cnt + 1;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_resp(input logic [7:0] b, output int t);
    resp_sig  = 1'b1;
    resp_data = b;
    t         = cyc;
    cycles(1);
    resp_sig  = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      cycles(1);
      k++;
    end
    if (got_q.size() < n) chk("strobe_timeout", 32'(got_q.size()), 32'(n));
  endtask

  task automatic check_next(input string tag, input logic [7:0] exp, input bit exp_done);
    logic [7:0] b;
    bit         d;
    int         c;
    if (got_q.size() == 0) begin
      chk({tag, "_present"}, 32'(got_q.size()), 32'd1);
    end else begin
      b = got_q.pop_front();
      d = done_q.pop_front();
      c = scyc_q.pop_front();
      chk(tag, 32'(b), 32'(exp));
      chk({tag, "_done"}, 32'(d), 32'(exp_done));
    end
  endtask

  task automatic flush();
    got_q.delete();
    done_q.delete();
    scyc_q.delete();
  endtask

  task automatic wait_bram_en(input int budget);
    int k = 0;
    while (!bram_en && k < budget) begin
      cycles(1);
      k++;
    end
    if (!bram_en) chk("bram_en_timeout", 32'(bram_en), 32'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_resp_drop"},     32'(resp_drop),     32'd0);
    chk({tag, "_bram_en"},       32'(bram_en),       32'd0);
    chk({tag, "_bram_addr"},     32'(bram_addr),     32'd0);
    chk({tag, "_uart_tx_sig"},   32'(uart_tx_sig),   32'd0);
    chk({tag, "_uart_tx_data"},  32'(uart_tx_data),  32'd0);
    chk({tag, "_stream_active"}, 32'(stream_active), 32'd0);
    chk({tag, "_stream_done"},   32'(stream_done),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int t;
    int base;
    logic [7:0] a, b;

    cycles(3);
    check_outputs_zero("reset");
    reset = 1'b1;
    cycles(5);

    // Response latency with the UART idle and no holdoff.
    pulse_resp(8'hF0, t);
    wait_strobes(1, 20);
    if (scyc_q.size() > 0) chk("resp_latency", 32'(scyc_q[0]), 32'(t + 2));
    check_next("resp_f0", 8'hF0, 1'b0);
    chk("resp_no_bram", 32'(bram_cnt), 32'd0);

    // Random responses against a busy-varying UART.
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom);
      cycles($urandom_range(1, 6));
      pulse_resp(a, t);
      wait_strobes(1, 40);
      check_next("resp_rand", a, 1'b0);
    end
    chk("resp_rand_no_drop", 32'(drop_cnt), 32'd0);

    // Stream with BRAM holding its own address.
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'(i);
    rom_en = 1'b1;
    wait_strobes(NBYTES, 200);
    for (int i = 0; i < NBYTES; i++) check_next("stream_a", mem[i], i == LAST_ADDR);
`ifdef BRAM_TX_LOOP_EN
    wait_strobes(NBYTES, 200);
    for (int i = 0; i < NBYTES; i++) check_next("stream_wrap", mem[i], i == LAST_ADDR);
    rom_en = 1'b0;
    cycles(2);
    chk("stream_stop_active", 32'(stream_active), 32'd0);
    cycles(30);
    flush();
`else
    cycles(40);
    chk("stream_stop_no_more", 32'(got_q.size()), 32'd0);
    chk("stream_stop_active", 32'(stream_active), 32'd0);
    chk("stream_stop_reads", 32'(bram_cnt), 32'(NBYTES));
    rom_en = 1'b0;
    cycles(2);
`endif

    // Response arriving while a read is in flight.
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'($urandom);
    rom_en = 1'b1;
    wait_bram_en(50);
    pulse_resp(8'hFA, t);
    wait_strobes(NBYTES + 1, 300);
    check_next("mid_stream0", mem[0], 1'b0);
    check_next("mid_resp",    8'hFA,  1'b0);
    for (int i = 1; i < NBYTES; i++) check_next("mid_stream", mem[i], i == LAST_ADDR);
    rom_en = 1'b0;
    cycles(30);
    flush();

    // Two responses while the UART is busy: one drop, only the second is sent.
    base = drop_cnt;
    hold_busy = 1'b1;
    pulse_resp(8'hFA, t);
    pulse_resp(8'hFB, t);
    cycles(10);
    chk("drop_count", 32'(drop_cnt - base), 32'd1);
    chk("drop_held", 32'(got_q.size()), 32'd0);
    hold_busy = 1'b0;
    wait_strobes(1, 40);
    check_next("drop_sent", 8'hFB, 1'b0);
    cycles(20);
    chk("drop_single", 32'(got_q.size()), 32'd0);

    // New response on the same edge the old pending one is granted.
    a = 8'($urandom);
    b = 8'($urandom);
    base = drop_cnt;
    hold_busy = 1'b1;
    pulse_resp(a, t);
    cycles(3);
    hold_busy = 1'b0;
    pulse_resp(b, t);
    wait_strobes(2, 60);
    check_next("simul_old", a, 1'b0);
    check_next("simul_new", b, 1'b0);
    chk("simul_no_drop", 32'(drop_cnt - base), 32'd0);
    cycles(10);

    // Reset during a BRAM read.
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'($urandom);
    rom_en = 1'b1;
    wait_bram_en(50);
    reset = 1'b0;
    #1;
    check_outputs_zero("midreset");
    rom_en = 1'b0;
    cycles(2);
    reset = 1'b1;
    base = bram_cnt;
    cycles(30);
    chk("postreset_no_strobe", 32'(got_q.size()), 32'd0);
    chk("postreset_no_read", 32'(bram_cnt - base), 32'd0);
    rom_en = 1'b1;
    wait_strobes(1, 100);
    check_next("restart_first", mem[0], 1'b0);
    rom_en = 1'b0;
    cycles(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bram_tx_scheduler.md
# bram_tx_scheduler

Shares the single RS485 UART transmitter between two sources: one-byte command responses from the main command controller, and a byte stream read sequentially out of the data BRAM while `rom_en` is high. It sequences BRAM reads (address counter, read strobe, capture) and paces every transmit against `uart_idle`. Responses always win a free transmit slot. The block sits between the command controller, the data BRAM read port and the UART TX core.

## Interface
Parameters:
- `ADDR_W`, 10: BRAM address width.
- `LAST_ADDR`, 1023: final stream address. Must be ≤ 2^ADDR_W−1.
- `IDLE_HOLDOFF`, 2: cycles after a `uart_tx_sig` pulse during which `uart_idle` is ignored. Must be ≥ 1.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `rom_en`  in  1  stream enable (level), from the command controller.
- `resp_sig`  in  1  one-cycle request to send `resp_data`.
- `resp_data`  in  8  response byte.
- `resp_drop`  out  1  one-cycle pulse: a pending response byte was overwritten.
- `bram_en`  out  1  BRAM read strobe. BRAM data is registered: valid the cycle after the strobe is sampled.
- `bram_addr`  out  ADDR_W  BRAM read address.
- `bram_dout`  in  8  BRAM read data.
- `uart_idle`  in  1  UART TX free.
- `uart_tx_sig`  out  1  one-cycle transmit strobe.
- `uart_tx_data`  out  8  transmit byte, held until the next strobe.
- `stream_active`  out  1  stream running.
- `stream_done`  out  1  one-cycle pulse when byte `LAST_ADDR` is strobed.

## Operation
- **Reset values:** all outputs 0, state ST_IDLE, address counter 0, response pending flag 0, holdoff counter 0. Asserting reset mid-transfer aborts immediately; no partial strobe is emitted.
- **Response capture:** `resp_sig` loads the holding register and sets `pend`. If `pend` is already set, the byte is replaced and `resp_drop` pulses.
- **Stream control:**
  - A rising edge of `rom_en` sets `stream_active` and clears the address counter to 0.
  - `rom_en` low clears `stream_active`. A read already issued still completes and transmits.
- **State machine:**
  - **ST_IDLE:** a slot is free when `holdoff_cnt == 0` and `uart_idle == 1`.
    - If `pend`: drive `uart_tx_data <= resp byte`, pulse `uart_tx_sig`, clear `pend`, load `holdoff_cnt <= IDLE_HOLDOFF`, stay in ST_IDLE.
    - Else if `stream_active`: drive `bram_en <= 1`, `bram_addr <= addr`, go to ST_READ.
  - **ST_READ:** `bram_en <= 0`, go to ST_CAPTURE.
  - **ST_CAPTURE:** drive `uart_tx_data <= bram_dout`, pulse `uart_tx_sig`, load holdoff, go to ST_IDLE.
    - If `addr == LAST_ADDR`: pulse `stream_done`, then either wrap or stop (see Configuration).
    - Else `addr <= addr + 1`.
- **Arbitration:** a stream read in progress is never preempted. A response arriving during ST_READ or ST_CAPTURE takes the next free slot.
- **Holdoff counter:** decrements to 0 in every state.
- **Simultaneous `resp_sig` and slot grant to an old `pend`:** the old byte is sent, the new byte becomes pending, and there is no `resp_drop`.

## Timing
- **Response latency** (UART idle, no holdoff): `resp_sig` at cycle 0, `uart_tx_sig` at cycle 2.
- **Stream latency:** grant in ST_IDLE at edge n; `bram_en` high n+1 → n+2; `uart_tx_sig` high n+3 → n+4.
- `uart_tx_sig`, `stream_done` and `resp_drop` are exactly one cycle wide.
- Minimum spacing between strobes is `IDLE_HOLDOFF`+1 cycles. The UART TX core must deassert `uart_idle` within `IDLE_HOLDOFF` cycles of a strobe.

## Configuration
- `BRAM_TX_LOOP_EN` **defined:** at `LAST_ADDR` the address wraps to 0 and streaming continues while `rom_en` is high. `stream_done` pulses on every wrap.
- **Not defined:** at `LAST_ADDR`, `stream_active` clears. Restart requires a new `rom_en` rising edge.

## Structure
- **Shared package `bram_tx_pkg`:** state encoding (ST_IDLE=0, ST_READ=1, ST_CAPTURE=2, 2-bit) and the default `ADDR_W`/`LAST_ADDR` constants.
- **One sub-module, `tx_holdoff_timer`:** load, decrement, zero flag.
- Arbitration and address logic stay in the top level.

## Test plan
- Reset released, UART idle, `resp_sig` with 0xF0 → `uart_tx_sig` 2 cycles later with data 0xF0; no BRAM access.
- BRAM preloaded with addr[7:0], `LAST_ADDR`=3, `rom_en` rising, UART idle → bytes 00,01,02,03 strobed.
  - `stream_done` pulses with the 03 strobe.
  - Without the macro, `stream_active` goes 0 and no further reads occur.
- Same setup, `BRAM_TX_LOOP_EN` defined → 00,01,02,03,00,01…; `stream_done` pulses on each 03.
- Stream running; `resp_sig` 0xFA arrives during ST_READ → the stream byte is sent first, then 0xFA in the next free slot; byte order stays intact.
- Two `resp_sig` pulses (0xFA, then 0xFB) while `uart_idle`=0 → `resp_drop` pulses once; only 0xFB is sent once `uart_idle` returns.
- Reset asserted during ST_READ → all outputs 0 immediately, `addr`=0, no strobe after release until a new request.
